bcd_countdown_timer: RTL
========================

# bcd_countdown_timer

Parametrised BCD timer: divides `clk` down to a configurable tick, counts a DIGITS-wide BCD value down to zero or up to a preset limit, and drives one active-low 7-segment pattern per digit. It is the general round/session timer for the game datapath, replacing fixed-width one-minute timers. Start, stop, load and direction are controlled by software or the game FSM.

## Interface
- `CLOCK_HZ`, 50000000: input clock frequency.
- `TICK_HZ`, 100: count rate. TICK_DIV = CLOCK_HZ/TICK_HZ. Requires exact divisibility and TICK_DIV ≥ 2; otherwise elaboration error.
- `DIGITS`, 4: number of BCD digits, 1..8.
- `INIT_BCD`, 'h6000: preset, DIGITS*4 bits; every nibble ≤ 9.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `load` in 1: reload counter from preset; return to IDLE.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `down` in 1: direction select. 1 = count down to 0; 0 = count up from 0 to INIT_BCD.
- `bcd` out DIGITS*4: current value; nibble 0 is the least-significant digit.
- `hex` out DIGITS*8: per-digit segments {dp,g,f,e,d,c,b,a}, active-low; byte i corresponds to nibble i.
- `running` out 1: state == RUN.
- `finish` out 1: one-cycle terminal pulse.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Latched direction:** `dir_q` is captured from `down` on load, on reset, and on every IDLE→RUN transition. It is held through RUN, PAUSE and DONE.
- **Preset:** INIT_BCD when the captured direction is down; 0 when up.
- **Priority per cycle:** reset > load > stop > start > tick.
- **load:** bcd ← preset (using the current `down`), prescaler ← TICK_DIV-1, state ← IDLE, finish ← 0.
- **start:** IDLE/PAUSE → RUN. Ignored in DONE and RUN.
- **stop:** RUN → PAUSE. Prescaler holds its value, so a resume finishes the partial tick. Ignored in other states.
- **Prescaler:** decrements only in RUN. At 0 with no stop asserted, a tick fires and the prescaler reloads TICK_DIV-1.
- **Tick, down direction:** BCD decrement with borrow; a digit at 0 becomes 9 and borrows from the next digit.
- **Tick, up direction:** BCD increment with carry; a digit at 9 becomes 0 and carries.
- **Terminal value:** 0 when counting down; INIT_BCD when counting up.
- **Reaching terminal:** the tick that produces the terminal value loads it into bcd, sets finish = 1 for that cycle, and enters DONE (or follows the Configuration behaviour).
- **Start at terminal:** start in IDLE with bcd already at terminal (e.g. INIT_BCD = 0) goes straight to DONE next cycle with a finish pulse, without counting.
- **Segment decode:** combinational from bcd. Patterns: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90; nibble > 9 → FF. dp is always 1 (off).

## Timing
- **Reset values:** state IDLE, bcd = INIT_BCD (direction down), prescaler = TICK_DIV-1, finish = 0, running = 0, hex = decode(INIT_BCD).
- **First tick:** arrives TICK_DIV cycles after the cycle in which start is sampled (RUN entered on the next edge). Subsequent ticks are every TICK_DIV cycles.
- **bcd update:** on the edge of the tick; hex follows with zero added latency. finish is high in the same cycle bcd first shows the terminal value.
- **running:** rises one cycle after start is sampled and falls one cycle after stop is sampled.
- **Stop on the tick cycle:** the tick is suppressed and the prescaler stays at 0, so the tick fires on the first RUN cycle after resume.
- **Reset or load mid-RUN:** any pending tick is discarded; no finish pulse.
- **Hold conditions:** bcd never changes outside RUN except by reset or load.

## Configuration
- **`BCD_TIMER_AUTORELOAD_EN` defined:** at terminal, bcd ← preset (not terminal), finish pulses, state stays RUN, and the prescaler continues without a gap. This gives periodic operation.
- **`BCD_TIMER_AUTORELOAD_EN` undefined:** behaviour as above, DONE is held until load or reset.

## Test plan
- **Reset values:** CLOCK_HZ=1000, TICK_HZ=100 (TICK_DIV=10), DIGITS=4, INIT_BCD='h0003, down=1. Assert reset → bcd=0003, hex[7:0]=B0, hex[15:8]=C0, running=0, finish=0.
- **Countdown to DONE:** start one cycle → bcd 0002 at +10, 0001 at +20, 0000 at +30 cycles after RUN entry. finish pulses once at 0000, state DONE. With autoreload: bcd=0003, running stays 1.
- **Borrow across digits:** INIT_BCD='h1000, down → first tick gives 0999. Up direction from 0099 → 0100. Up terminal INIT_BCD='h0012 reached after 12 ticks with one finish pulse.
- **Pause and resume:** stop at 4 cycles into a tick, hold 50 cycles → bcd unchanged, running=0. start → next tick 6 cycles after RUN re-entry.
- **Simultaneous controls:** start+stop while IDLE → stays IDLE. load+start in RUN → IDLE, bcd=preset, no tick. stop on the tick cycle → bcd unchanged, tick arrives on the first resumed cycle.
- **Reset mid-run and decode:** reset while RUN with bcd=0001 and prescaler=0 → next cycle bcd=INIT_BCD, no finish pulse. Force each nibble 0..9 and check hex against the pattern list.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: prescaled BCD up/down timer with 7-segment decode.
// Optional BCD_TIMER_AUTORELOAD_EN: reload preset at terminal and keep running.
module bcd_countdown_timer #(
  parameter int unsigned         CLOCK_HZ = 50000000,
  parameter int unsigned         TICK_HZ  = 100,
  parameter int unsigned         DIGITS   = 4,
  parameter logic [DIGITS*4-1:0] INIT_BCD = 'h6000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  down,
  output logic [DIGITS*4-1:0]   bcd,
  output logic [DIGITS*8-1:0]   hex,
  output logic                  running,
  output logic                  finish
);

  localparam int unsigned W        = DIGITS * 4;
  localparam int unsigned TICK_DIV = CLOCK_HZ / TICK_HZ;
  localparam int unsigned PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  if (CLOCK_HZ % TICK_HZ != 0 || TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be an exact integer >= 2");
  end

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("DIGITS must be in 1..8");
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    if (INIT_BCD[g*4 +: 4] > 4'd9) begin : g_bad_nib
      $error("INIT_BCD nibble above 9");
    end
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state;
  logic          dir_q;
  logic [W-1:0]  bcd_q;
  logic [PW-1:0] pre_q;
  logic [W-1:0]  step_val;
  logic [W-1:0]  run_term;
  logic [W-1:0]  start_term;
  logic [W-1:0]  load_val;
  logic          cy;
  logic [3:0]    dig;

  // terminal/preset values for the latched and the live direction
  assign run_term   = dir_q ? '0 : INIT_BCD;
  assign start_term = down ? '0 : INIT_BCD;
  assign load_val   = down ? INIT_BCD : '0;

  // one BCD step in the latched direction, rippling borrow/carry
  always_comb begin
    step_val = '0;
    cy       = 1'b1;
    dig      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = bcd_q[i*4 +: 4];
      if (!cy) begin
        step_val[i*4 +: 4] = dig;
      end else if (dir_q) begin
        step_val[i*4 +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
        cy = (dig == 4'd0);
      end else begin
        step_val[i*4 +: 4] = (dig >= 4'd9) ? 4'd0 : dig + 4'd1;
        cy = (dig >= 4'd9);
      end
    end
  end

  // control FSM, prescaler and counter with registered flags
  always_ff @(posedge clk) begin
    if (reset || load) begin
      state   <= S_IDLE;
      running <= 1'b0;
      finish  <= 1'b0;
      dir_q   <= down;
      bcd_q   <= load_val;
      pre_q   <= PRE_MAX;
    end else begin
      finish <= 1'b0;
      if (stop) begin
        if (state == S_RUN) begin
          state   <= S_PAUSE;
          running <= 1'b0;
        end
      end else if (start && (state == S_IDLE ||
                             state == S_PAUSE)) begin
        if (state == S_IDLE) dir_q <= down;
        if (state == S_IDLE && bcd_q == start_term) begin
          state  <= S_DONE;
          finish <= 1'b1;
        end else begin
          state   <= S_RUN;
          running <= 1'b1;
        end
      end else if (state == S_RUN) begin
        if (pre_q == '0) begin
          pre_q <= PRE_MAX;
          if (step_val == run_term) begin
            finish <= 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
            bcd_q  <= dir_q ? INIT_BCD : '0;
`else
            bcd_q   <= step_val;
            state   <= S_DONE;
            running <= 1'b0;
`endif
          end else begin
            bcd_q <= step_val;
          end
        end else begin
          pre_q <= pre_q - PW'(1);
        end
      end
    end
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // per-digit active-low segment decode
  always_comb begin
    hex = '1;
    for (int i = 0; i < DIGITS; i++) begin
      hex[i*8 +: 8] = seg7(bcd_q[i*4 +: 4]);
    end
  end

  assign bcd = bcd_q;

endmodule
